// File: rtl/regfile_pkg.sv
// Shared constants for the general-purpose register file: bus widths and the
// polarity of the reset / write / read enables.
package regfile_pkg;
    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 1 << REG_ADDR_W;

    localparam logic [REG_BUS_W-1:0] ZERO_WORD = '0;
    localparam logic RST_ENABLE   = 1'b1;
    localparam logic WRITE_ENABLE = 1'b1;
    localparam logic READ_ENABLE  = 1'b1;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational read port: reset/enable/$0 gating, then write-first bypass,
// then the stored entry.
module regfile_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              rst,
    input  logic              read_en,
    input  logic [ADDR_W-1:0] read_addr,
    input  logic              write_en,
    input  logic [ADDR_W-1:0] write_addr,
    input  logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] regs [NUM_REGS],
    output logic [DATA_W-1:0] read_data
);
    always_comb begin
        read_data = '0;
        if (rst == RST_ENABLE) begin
            read_data = '0;
        end else if (read_en != READ_ENABLE) begin
            read_data = '0;
        end else if (read_addr == '0) begin
            // $0 wins even over a bypassed write to $0.
            read_data = '0;
        end else if (write_en == WRITE_ENABLE && write_addr == read_addr) begin
            read_data = write_data;
        end else begin
            read_data = regs[read_addr];
        end
    end
endmodule

// File: rtl/regfile.sv
// General-purpose register file: one synchronous write port from write-back,
// two combinational read ports with same-cycle bypass; $0 is hard zero.
module regfile
    import regfile_pkg::*;
#(
    parameter int DATA_W   = REG_BUS_W,
    parameter int ADDR_W   = REG_ADDR_W,
    parameter int NUM_REGS = REG_NUM
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              writeReg_i,
    input  logic [ADDR_W-1:0] writeAddr_i,
    input  logic [DATA_W-1:0] writeData_i,
    input  logic              readReg1_i,
    input  logic [ADDR_W-1:0] readAddr1_i,
    output logic [DATA_W-1:0] readData1_o,
    input  logic              readReg2_i,
    input  logic [ADDR_W-1:0] readAddr2_i,
    output logic [DATA_W-1:0] readData2_o
);
    logic [DATA_W-1:0] regs [NUM_REGS];

    // Reset has priority, so a write presented during reset is dropped.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (writeReg_i == WRITE_ENABLE && writeAddr_i != '0) begin
            regs[writeAddr_i] <= writeData_i;
        end
    end

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd1 (
        .rst        (rst),
        .read_en    (readReg1_i),
        .read_addr  (readAddr1_i),
        .write_en   (writeReg_i),
        .write_addr (writeAddr_i),
        .write_data (writeData_i),
        .regs       (regs),
        .read_data  (readData1_o)
    );

    regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_REGS(NUM_REGS)) u_rd2 (
        .rst        (rst),
        .read_en    (readReg2_i),
        .read_addr  (readAddr2_i),
        .write_en   (writeReg_i),
        .write_addr (writeAddr_i),
        .write_data (writeData_i),
        .regs       (regs),
        .read_data  (readData2_o)
    );
endmodule

// File: tb/tb_regfile.sv
// Directed vector table plus reset / random-scoreboard sequences for regfile.
module tb_regfile;
    logic        clk = 1'b0;
    logic        rst;
    logic        writeReg_i;
    logic [4:0]  writeAddr_i;
    logic [31:0] writeData_i;
    logic        readReg1_i;
    logic [4:0]  readAddr1_i;
    logic [31:0] readData1_o;
    logic        readReg2_i;
    logic [4:0]  readAddr2_i;
    logic [31:0] readData2_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile dut (
        .clk         (clk),
        .rst         (rst),
        .writeReg_i  (writeReg_i),
        .writeAddr_i (writeAddr_i),
        .writeData_i (writeData_i),
        .readReg1_i  (readReg1_i),
        .readAddr1_i (readAddr1_i),
        .readData1_o (readData1_o),
        .readReg2_i  (readReg2_i),
        .readAddr2_i (readAddr2_i),
        .readData2_o (readData2_o)
    );

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic [31:0] exp1;
        logic [31:0] exp2;
    } vec_t;

    vec_t vecs [15];
    logic [31:0] model [32];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive just after a posedge; outputs are sampled mid-cycle, and any write
    // commits on the following posedge.
    task automatic drive(input logic r, input logic we, input logic [4:0] wa, input logic [31:0] wd,
                         input logic re1, input logic [4:0] ra1, input logic re2, input logic [4:0] ra2);
        @(posedge clk);
        #1;
        rst = r; writeReg_i = we; writeAddr_i = wa; writeData_i = wd;
        readReg1_i = re1; readAddr1_i = ra1; readReg2_i = re2; readAddr2_i = ra2;
        #3;
    endtask

    function automatic logic [31:0] ref_read(input logic r, input logic re, input logic [4:0] a,
                                             input logic we, input logic [4:0] wa, input logic [31:0] wd);
        if (r || !re || a == 5'd0) return 32'h0;
        if (we && wa == a) return wd;
        return model[a];
    endfunction

    initial begin
        //            rst we  wa  wd            re1 ra1 re2 ra2 exp1          exp2
        vecs[0]  = '{1'b0,1'b1,5'd5, 32'h1234_5678,1'b1,5'd6, 1'b1,5'd5, 32'h0,        32'h1234_5678};
        vecs[1]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd5, 1'b1,5'd6, 32'h1234_5678,32'h0};
        vecs[2]  = '{1'b0,1'b1,5'd0, 32'hFFFF_FFFF,1'b1,5'd0, 1'b1,5'd0, 32'h0,        32'h0};
        vecs[3]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd0, 1'b1,5'd0, 32'h0,        32'h0};
        vecs[4]  = '{1'b0,1'b1,5'd7, 32'h1,        1'b0,5'd7, 1'b0,5'd7, 32'h0,        32'h0};
        vecs[5]  = '{1'b0,1'b1,5'd7, 32'hDEAD_BEEF,1'b1,5'd7, 1'b1,5'd7, 32'hDEAD_BEEF,32'hDEAD_BEEF};
        vecs[6]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd7, 1'b1,5'd7, 32'hDEAD_BEEF,32'hDEAD_BEEF};
        vecs[7]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b0,5'd7, 1'b1,5'd7, 32'h0,        32'hDEAD_BEEF};
        vecs[8]  = '{1'b1,1'b1,5'd3, 32'h55,       1'b1,5'd7, 1'b1,5'd3, 32'h0,        32'h0};
        vecs[9]  = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd3, 1'b1,5'd7, 32'h0,        32'h0};
        vecs[10] = '{1'b0,1'b1,5'd3, 32'hAA,       1'b1,5'd3, 1'b1,5'd31,32'hAA,       32'h0};
        vecs[11] = '{1'b0,1'b1,5'd4, 32'h77,       1'b1,5'd3, 1'b1,5'd4, 32'hAA,       32'h77};
        vecs[12] = '{1'b0,1'b1,5'd31,32'h8000_0001,1'b1,5'd31,1'b1,5'd4, 32'h8000_0001,32'h77};
        vecs[13] = '{1'b0,1'b1,5'd9, 32'h99,       1'b0,5'd9, 1'b1,5'd31,32'h0,        32'h8000_0001};
        vecs[14] = '{1'b0,1'b0,5'd0, 32'h0,        1'b1,5'd9, 1'b1,5'd3, 32'h99,       32'hAA};

        rst = 1'b1; writeReg_i = 1'b0; writeAddr_i = '0; writeData_i = '0;
        readReg1_i = 1'b0; readAddr1_i = '0; readReg2_i = 1'b0; readAddr2_i = '0;
        repeat (2) @(posedge clk);

        // Fill every register, then pulse reset and confirm everything reads zero.
        for (int i = 1; i < 32; i++)
            drive(1'b0, 1'b1, 5'(i), 32'hA5A5_0000 + 32'(i), 1'b0, 5'd0, 1'b0, 5'd0);
        drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd31);
        check("preload_p1", readData1_o, 32'hA5A5_0011);
        check("preload_p2", readData2_o, 32'hA5A5_001F);
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd17, 1'b1, 5'd31);
        check("in_reset_p1", readData1_o, 32'h0);
        check("in_reset_p2", readData2_o, 32'h0);
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));
            check($sformatf("post_reset_p1_a%0d", a), readData1_o, 32'h0);
            check($sformatf("post_reset_p2_a%0d", 31 - a), readData2_o, 32'h0);
        end

        for (int i = 0; i < 15; i++) begin
            drive(vecs[i].rst, vecs[i].we, vecs[i].wa, vecs[i].wd,
                  vecs[i].re1, vecs[i].ra1, vecs[i].re2, vecs[i].ra2);
            check($sformatf("vec%0d_p1", i), readData1_o, vecs[i].exp1);
            check($sformatf("vec%0d_p2", i), readData2_o, vecs[i].exp2);
        end

        // Random traffic against a reference model, starting from a fresh reset.
        drive(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
        for (int i = 0; i < 32; i++) model[i] = 32'h0;
        for (int c = 0; c < 10000; c++) begin
            logic        r, we, re1, re2;
            logic [4:0]  wa, ra1, ra2;
            logic [31:0] wd;
            r   = ($urandom_range(0, 99) == 0);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            re1 = ($urandom_range(0, 7) != 0);
            re2 = ($urandom_range(0, 7) != 0);
            ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            ra2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            drive(r, we, wa, wd, re1, ra1, re2, ra2);
            check($sformatf("rand%0d_p1", c), readData1_o, ref_read(r, re1, ra1, we, wa, wd));
            check($sformatf("rand%0d_p2", c), readData2_o, ref_read(r, re2, ra2, we, wa, wd));
            if (r) begin
                for (int i = 0; i < 32; i++) model[i] = 32'h0;
            end else if (we && wa != 5'd0) begin
                model[wa] = wd;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
